cw305_usb_bus_master: RTL and testbench
=======================================

// Module: cw305_usb_bus_master
// PURPOSE
//  Initiator side of the CW305 8-bit parallel USB register bus (addr/data/!RD/!WR/!CE/trigger).
//  Converts a command/stream interface into timed bus cycles that drive a cw305_usb_reg_fe target.
//  Used as the host-side bus engine in system sims and as a loopback driver for on-board self-test.
// PARAMETERS
//  pADDR_WIDTH   21  bus address width; matches target usb_addr
//  pBYTECNT_SIZE 7   burst length field width; max burst = 2**pBYTECNT_SIZE bytes
//  pSETUP_CYC    2   cycles with addr/data valid and cen low before strobe (>=1)
//  pSTROBE_CYC   3   cycles rdn/wrn held low (>=1)
//  pHOLD_CYC     1   cycles addr/data held after strobe release (>=1)
// PORTS
//  usb_clk      in  1            single clock; all logic on posedge
//  reset_i      in  1            synchronous, active-high reset
//  cmd_valid    in  1            command offered
//  cmd_ready    out 1            high only in IDLE; accept = cmd_valid & cmd_ready
//  cmd_write    in  1            1 = write burst, 0 = read burst
//  cmd_addr     in  pADDR_WIDTH  start address
//  cmd_len      in  pBYTECNT_SIZE beats minus 1 (0 = single byte)
//  wr_valid     in  1            write byte available
//  wr_ready     out 1            one-cycle pulse: wr_data consumed for current beat
//  wr_data      in  8            write byte
//  rd_valid     out 1            one-cycle pulse: rd_data holds a read byte
//  rd_data      out 8            read byte, held until next rd_valid
//  trig_req     in  1            trigger request from host logic
//  busy         out 1            high from accept until bus returns to IDLE
//  usb_addr     out pADDR_WIDTH  bus address
//  usb_dout     out 8            bus write data
//  usb_doe      out 1            drive enable for usb_dout (tristate control at top level)
//  usb_din      in  8            bus read data
//  usb_rdn/usb_wrn/usb_cen out 1 active-low strobes / chip enable
//  usb_trigger  out 1            trig_req registered one cycle
// BEHAVIOUR
//  Reset: cmd_ready=1 (after release), busy=0, usb_cen=usb_rdn=usb_wrn=1, usb_doe=0,
//   usb_addr=0, usb_dout=0, rd_valid=0, rd_data=0, wr_ready=0, usb_trigger=0. All outputs registered.
//  FSM: IDLE -> (accept) WAITD (write only) -> SETUP -> STROBE -> HOLD -> SETUP|WAITD (more beats) | IDLE.
//  Accept at edge T: usb_addr=cmd_addr, usb_cen=0, busy=1 from T+1; read goes straight to SETUP.
//  WAITD: strobes high, cen low; stays until wr_valid; on wr_valid: wr_ready pulse, usb_dout=wr_data, doe=1, -> SETUP.
//  SETUP pSETUP_CYC cycles; STROBE pSTROBE_CYC cycles with rdn (read) or wrn (write) low; HOLD pHOLD_CYC.
//  Read: usb_din sampled on last STROBE cycle; rd_valid pulses first HOLD cycle.
//  Beat length S+P+H cycles (+WAITD stall). Next beat: usb_addr increments, wraps mod 2**pADDR_WIDTH.
//  usb_doe high WAITD-exit through last HOLD of a write beat only; never high during a read.
//  Last beat's HOLD ends: cen=1, doe=0, busy=0, IDLE; cmd_ready=1 the following cycle; back-to-back
//   commands thus have >=1 cycle with cen high.
//  cmd_valid ignored while busy; cmd_* sampled only at accept.
//  rdn and wrn never low together; strobe never low while cen high.
//  reset_i mid-burst: next edge all reset values; no further rd_valid/wr_ready.
//  usb_trigger independent of FSM; follows trig_req with 1-cycle latency, also in reset=0.
// CONFIGURATION
//  CW305_BUS_MASTER_BURST_EN defined: cmd_len honoured, address auto-increment per beat.
//  Not defined: cmd_len ignored, every command is exactly one beat; burst counter not built.
// STRUCTURE
//  cw305_bus_master_defs.vh: state encodings (localparam), timing-counter width via $clog2(max(S,P,H)+1).
//  Sub-module cw305_bus_timer: loadable down-counter, load value + done flag; one instance shared by
//   SETUP/STROBE/HOLD phases. Beat counter and address incrementer stay in this module.
// TESTING
//  Write 1 byte addr 0x00A80 data 0x5A, S/P/H=2/3/1 -> wrn low exactly 3 cycles, doe spans 6, cen rises after HOLD.
//  Read 1 byte addr 0x00100, usb_din=0xC3 stable -> rd_valid one cycle, rd_data=0xC3, rdn low 3 cycles.
//  BURST_EN, read cmd_len=3 addr 0x1FFFFE -> 4 beats, addrs 1FFFFE,1FFFFF,000000,000001; 4 rd_valid pulses.
//  BURST_EN, write len=1, wr_valid low 5 cycles before 2nd byte -> stall in WAITD, wrn high, cen low, then completes.
//  reset_i asserted in 2nd STROBE cycle of read -> next cycle rdn=cen=1, busy=0, no rd_valid ever issued.
//  No BURST_EN, cmd_len=5 -> single beat only; trig_req pulse -> usb_trigger pulse 1 cycle later.

Source files
------------

// File: rtl/cw305_usb_bus_master_pkg.sv
// Shared types and helpers for the CW305 USB bus master.
//   state_t : bus-cycle FSM encoding
//   max3()  : largest of three phase lengths, sizes the shared phase timer
package cw305_usb_bus_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAITD  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cw305_usb_bus_master_timer.sv
// Loadable down-counter used for the SETUP/STROBE/HOLD phase lengths.
// Ports:
//   usb_clk, reset_i : clock, synchronous active-high reset
//   load, load_val   : restart the count at load_val (phase length minus 1)
//   done             : count has reached zero (last cycle of the phase)
module cw305_usb_bus_master_timer #(
  parameter int W = 2
) (
  input  logic         usb_clk,
  input  logic         reset_i,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge usb_clk) begin
    if (reset_i)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign done = (count == '0);

endmodule

// File: rtl/cw305_usb_bus_master.sv
// Initiator for the CW305 8-bit parallel USB register bus. Turns accepted
// commands into SETUP/STROBE/HOLD bus cycles; writes pull one byte per beat
// from the wr_* stream, reads return one byte per beat on rd_*.
// Ports:
//   usb_clk, reset_i          : clock, synchronous active-high reset
//   cmd_*                     : command handshake (write flag, start address, beats-1)
//   wr_valid/wr_ready/wr_data : write byte stream, wr_ready pulses on consumption
//   rd_valid/rd_data          : read byte stream, rd_valid pulses per byte
//   trig_req/usb_trigger      : trigger passthrough, one cycle latency
//   busy                      : command in progress
//   usb_*                     : bus pins (active-low rdn/wrn/cen, doe = dout drive enable)
// Build option: CW305_BUS_MASTER_BURST_EN enables multi-beat bursts with
// address auto-increment; without it every command is a single beat.
//
// state  | meaning
// IDLE   | cen high, ready for a command
// WAITD  | write beat waiting for a data byte, strobes high
// SETUP  | address/data valid, strobes high
// STROBE | rdn or wrn low
// HOLD   | strobe released, address/data still held
module cw305_usb_bus_master
  import cw305_usb_bus_master_pkg::*;
#(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pSETUP_CYC    = 2,
  parameter int pSTROBE_CYC   = 3,
  parameter int pHOLD_CYC     = 1
) (
  input  logic                     usb_clk,
  input  logic                     reset_i,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [pADDR_WIDTH-1:0]   cmd_addr,
  input  logic [pBYTECNT_SIZE-1:0] cmd_len,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [7:0]               wr_data,
  output logic                     rd_valid,
  output logic [7:0]               rd_data,
  input  logic                     trig_req,
  output logic                     busy,
  output logic [pADDR_WIDTH-1:0]   usb_addr,
  output logic [7:0]               usb_dout,
  output logic                     usb_doe,
  input  logic [7:0]               usb_din,
  output logic                     usb_rdn,
  output logic                     usb_wrn,
  output logic                     usb_cen,
  output logic                     usb_trigger
);

  localparam int TW = $clog2(max3(pSETUP_CYC, pSTROBE_CYC, pHOLD_CYC) + 1);

  state_t          state, state_n;
  logic            is_wr, is_wr_n;
  logic            accept;
  logic            last_beat;
  logic            adv_beat;
  logic            rd_capture;
  logic            wr_take;
  logic            tmr_load;
  logic [TW-1:0]   tmr_load_val;
  logic            tmr_done;

  assign accept = (state == ST_IDLE) && cmd_valid && cmd_ready;

  cw305_usb_bus_master_timer #(.W(TW)) u_timer (
    .usb_clk  (usb_clk),
    .reset_i  (reset_i),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .done     (tmr_done)
  );

`ifdef CW305_BUS_MASTER_BURST_EN
  logic [pBYTECNT_SIZE-1:0] beats_left;

  always_ff @(posedge usb_clk) begin
    if (reset_i)
      beats_left <= '0;
    else if (accept)
      beats_left <= cmd_len;
    else if (adv_beat)
      beats_left <= beats_left - 1'b1;
  end

  assign last_beat = (beats_left == '0);
`else
  logic unused_cmd_len;
  assign unused_cmd_len = ^cmd_len;
  assign last_beat      = 1'b1;
`endif

  always_comb begin
    state_n      = state;
    is_wr_n      = is_wr;
    adv_beat     = 1'b0;
    rd_capture   = 1'b0;
    wr_take      = 1'b0;
    tmr_load_val = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          is_wr_n = cmd_write;
          state_n = cmd_write ? ST_WAITD : ST_SETUP;
        end
      end
      ST_WAITD: begin
        if (wr_valid) begin
          wr_take = 1'b1;
          state_n = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_done) state_n = ST_STROBE;
      end
      ST_STROBE: begin
        if (tmr_done) begin
          rd_capture = !is_wr;
          state_n    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tmr_done) begin
          if (last_beat) begin
            state_n = ST_IDLE;
          end else begin
            adv_beat = 1'b1;
            state_n  = is_wr ? ST_WAITD : ST_SETUP;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // Every transition is a phase change, so the timer reloads on any state change.
    case (state_n)
      ST_SETUP:  tmr_load_val = TW'(pSETUP_CYC - 1);
      ST_STROBE: tmr_load_val = TW'(pSTROBE_CYC - 1);
      ST_HOLD:   tmr_load_val = TW'(pHOLD_CYC - 1);
      default:   tmr_load_val = '0;
    endcase
  end

  assign tmr_load = (state_n != state);

  // Bus pins are registered from the next state so each pin changes exactly
  // on the edge that enters or leaves its phase.
  always_ff @(posedge usb_clk) begin
    if (reset_i) begin
      state       <= ST_IDLE;
      is_wr       <= 1'b0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      usb_cen     <= 1'b1;
      usb_rdn     <= 1'b1;
      usb_wrn     <= 1'b1;
      usb_doe     <= 1'b0;
      usb_addr    <= '0;
      usb_dout    <= '0;
      wr_ready    <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      usb_trigger <= 1'b0;
    end else begin
      state       <= state_n;
      is_wr       <= is_wr_n;
      cmd_ready   <= (state_n == ST_IDLE);
      busy        <= (state_n != ST_IDLE);
      usb_cen     <= (state_n == ST_IDLE);
      usb_rdn     <= !((state_n == ST_STROBE) && !is_wr_n);
      usb_wrn     <= !((state_n == ST_STROBE) && is_wr_n);
      usb_doe     <= is_wr_n && (state_n inside {ST_SETUP, ST_STROBE, ST_HOLD});
      wr_ready    <= wr_take;
      rd_valid    <= rd_capture;
      usb_trigger <= trig_req;
      if (wr_take)    usb_dout <= wr_data;
      if (rd_capture) rd_data  <= usb_din;
      if (accept)
        usb_addr <= cmd_addr;
      else if (adv_beat)
        usb_addr <= usb_addr + 1'b1;
    end
  end

endmodule

// File: tb/tb_cw305_usb_bus_master.sv
module tb_cw305_usb_bus_master;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [20:0] cmd_addr;
  logic [6:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_data;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        trig_req, busy;
  logic [20:0] usb_addr;
  logic [7:0]  usb_dout, usb_din;
  logic        usb_doe, usb_rdn, usb_wrn, usb_cen, usb_trigger;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cw305_usb_bus_master dut (
    .usb_clk     (clk),
    .reset_i     (reset_i),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .trig_req    (trig_req),
    .busy        (busy),
    .usb_addr    (usb_addr),
    .usb_dout    (usb_dout),
    .usb_doe     (usb_doe),
    .usb_din     (usb_din),
    .usb_rdn     (usb_rdn),
    .usb_wrn     (usb_wrn),
    .usb_cen     (usb_cen),
    .usb_trigger (usb_trigger)
  );

  typedef struct {
    logic        wr;
    logic [20:0] addr;
    logic [6:0]  len;
    logic [7:0]  data;
    logic [7:0]  din;
    int          stall;
    int          exp_wrn;
    int          exp_rdn;
    int          exp_doe;
    int          exp_rdv;
    int          exp_busy;
    int          exp_beats;
    int          exp_wrr;
    logic [7:0]  exp_rd_data;
    logic [7:0]  exp_dout;
    logic [20:0] exp_first;
    logic [20:0] exp_last;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int wrn_c = 0, rdn_c = 0, doe_c = 0, rdv_c = 0, busy_c = 0;
    int beats = 0, wrr_c = 0, viol = 0, idx = 0, waitd_low = 0;
    logic strobe, prev_strobe;
    logic [7:0]  last_rd, last_dout;
    logic [20:0] first_a, last_a;
    prev_strobe = 1'b0;
    last_rd = '0; last_dout = '0; first_a = '0; last_a = '0;
    chk({tag, "_ready_before"}, 32'(cmd_ready), 32'd1);
    usb_din   = v.din;
    wr_data   = v.data;
    wr_valid  = v.wr;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_len   = v.len;
    cmd_valid = 1'b1;
    @(negedge clk);
    chk({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
    chk({tag, "_cen_after_accept"}, 32'(usb_cen), 32'd0);
    chk({tag, "_addr_after_accept"}, 32'(usb_addr), 32'(v.addr));
    for (int it = 0; it < 400; it++) begin
      if (!busy) break;
      busy_c++;
      if (!usb_wrn) begin wrn_c++; last_dout = usb_dout; end
      if (!usb_rdn) rdn_c++;
      if (usb_doe) doe_c++;
      if (rd_valid) begin rdv_c++; last_rd = rd_data; end
      strobe = !usb_rdn || !usb_wrn;
      if (strobe && !prev_strobe) begin
        beats++;
        if (beats == 1) first_a = usb_addr;
        last_a = usb_addr;
      end
      prev_strobe = strobe;
      if ((!usb_rdn && !usb_wrn) || (strobe && usb_cen) || (usb_doe && !v.wr) ||
          (!usb_rdn && v.wr) || (!usb_wrn && !v.wr))
        viol++;
      if (wr_ready) begin
        wrr_c++;
        idx++;
        wr_data = v.data + 8'(idx);
        if (idx == 1 && v.stall > 0) wr_valid = 1'b0;
      end
      if (v.wr && !wr_valid && !usb_doe && !usb_cen && usb_wrn) begin
        waitd_low++;
        if (waitd_low >= v.stall) wr_valid = 1'b1;
      end
      if (it < 2) begin
        cmd_valid = 1'b1;
        cmd_write = !v.wr;
        cmd_addr  = ~v.addr;
        cmd_len   = '1;
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    wr_valid  = 1'b0;
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_cen_end"}, 32'(usb_cen), 32'd1);
    chk({tag, "_doe_end"}, 32'(usb_doe), 32'd0);
    chk({tag, "_ready_end"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_wrn_cycles"}, 32'(wrn_c), 32'(v.exp_wrn));
    chk({tag, "_rdn_cycles"}, 32'(rdn_c), 32'(v.exp_rdn));
    chk({tag, "_doe_cycles"}, 32'(doe_c), 32'(v.exp_doe));
    chk({tag, "_rd_valid_cycles"}, 32'(rdv_c), 32'(v.exp_rdv));
    chk({tag, "_busy_cycles"}, 32'(busy_c), 32'(v.exp_busy));
    chk({tag, "_beats"}, 32'(beats), 32'(v.exp_beats));
    chk({tag, "_wr_ready_pulses"}, 32'(wrr_c), 32'(v.exp_wrr));
    chk({tag, "_protocol_violations"}, 32'(viol), 32'd0);
    chk({tag, "_first_addr"}, 32'(first_a), 32'(v.exp_first));
    chk({tag, "_last_addr"}, 32'(last_a), 32'(v.exp_last));
    if (v.wr)
      chk({tag, "_last_dout"}, 32'(last_dout), 32'(v.exp_dout));
    else
      chk({tag, "_rd_data"}, 32'(last_rd), 32'(v.exp_rd_data));
  endtask

  initial begin : main
    int rdv_seen;
    int found;

    //          wr    addr        len   data   din    stall wrn rdn doe rdv busy beats wrr rd_data dout   first       last
    vecs[0] = '{1'b1, 21'h00A80, 7'd0, 8'h5A, 8'h00, 0,    3,  0,  6,  0,  7,   1,    1,  8'h00,  8'h5A, 21'h00A80, 21'h00A80};
    vecs[1] = '{1'b0, 21'h00100, 7'd0, 8'h00, 8'hC3, 0,    0,  3,  0,  1,  6,   1,    0,  8'hC3,  8'h00, 21'h00100, 21'h00100};
    vecs[2] = '{1'b0, 21'h1FFFFF, 7'd0, 8'h00, 8'h3C, 0,   0,  3,  0,  1,  6,   1,    0,  8'h3C,  8'h00, 21'h1FFFFF, 21'h1FFFFF};
`ifdef CW305_BUS_MASTER_BURST_EN
    vecs[3] = '{1'b0, 21'h1FFFFE, 7'd3, 8'h00, 8'h96, 0,   0, 12,  0,  4, 24,   4,    0,  8'h96,  8'h00, 21'h1FFFFE, 21'h000001};
    vecs[4] = '{1'b1, 21'h00010, 7'd1, 8'h11, 8'h00, 5,    6,  0, 12,  0, 18,   2,    2,  8'h00,  8'h12, 21'h00010, 21'h00011};
`else
    vecs[3] = '{1'b0, 21'h00200, 7'd5, 8'h00, 8'h81, 0,    0,  3,  0,  1,  6,   1,    0,  8'h81,  8'h00, 21'h00200, 21'h00200};
    vecs[4] = '{1'b1, 21'h1FFFFF, 7'd5, 8'hA5, 8'h00, 0,   3,  0,  6,  0,  7,   1,    1,  8'h00,  8'hA5, 21'h1FFFFF, 21'h1FFFFF};
`endif

    reset_i = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; trig_req = 1'b0; usb_din = '0;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", {29'd0, usb_cen, usb_rdn, usb_wrn}, 32'd7);
    chk("rst_doe", 32'(usb_doe), 32'd0);
    chk("rst_addr", 32'(usb_addr), 32'd0);
    chk("rst_dout", 32'(usb_dout), 32'd0);
    chk("rst_rd", {23'd0, rd_valid, rd_data}, 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_trigger", 32'(usb_trigger), 32'd0);

    trig_req = 1'b1;
    @(negedge clk);
    chk("trig_rise", 32'(usb_trigger), 32'd1);
    trig_req = 1'b0;
    @(negedge clk);
    chk("trig_fall", 32'(usb_trigger), 32'd0);

    for (int i = 0; i < 5; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset during the second STROBE cycle of a read.
    usb_din   = 8'h77;
    cmd_write = 1'b0;
    cmd_addr  = 21'h00300;
    cmd_len   = '0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (!usb_rdn) begin found = 1; break; end
      @(negedge clk);
    end
    chk("midrst_strobe_seen", 32'(found), 32'd1);
    @(negedge clk);
    chk("midrst_still_strobe", 32'(usb_rdn), 32'd0);
    reset_i = 1'b1;
    @(negedge clk);
    chk("midrst_rdn", 32'(usb_rdn), 32'd1);
    chk("midrst_cen", 32'(usb_cen), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
    reset_i = 1'b0;
    rdv_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (rd_valid) rdv_seen++;
    end
    chk("midrst_no_rd_valid", 32'(rdv_seen), 32'd0);
    chk("midrst_rd_data", 32'(rd_data), 32'd0);

    run_vec(vecs[1], "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
